// File: rtl/dac_sample_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sched_pkg
//  Purpose  : Shared types and constants for the DAC sample scheduler:
//             sample/word widths, the default DAC command byte, the
//             FILL/RUN state type and a word-formatting helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sched_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int DAC_WORD_W = 24;

  // Command byte: write DAC channel A
  localparam logic [7:0] DAC_CMD_CH_A = 8'b00110001;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [DAC_WORD_W-1:0] make_word(input logic [7:0]          cmd,
                                                      input logic [SAMPLE_W-1:0] sample);
    return {cmd, sample};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_sample_scheduler_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sample_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO, depth 2**ADDR_W.
//             A push into a full FIFO is dropped unless a pop happens in the
//             same cycle, in which case both take effect.
//  Ports    : clock_in, reset (sync, active-high)
//             push, wdata        - write side
//             pop, rdata         - read side, rdata shows the head
//             full, empty, level - occupancy, level in 0..depth
//  Revision : 1.0  initial release
// ============================================================================
module sample_fifo #(
  parameter int ADDR_W   = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic [ADDR_W:0]     level
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                wr_en;
  logic                rd_en;

  assign full  = (level == (ADDR_W+1)'(DEPTH));
  assign empty = (level == '0);
  assign rd_en = pop & ~empty;
  // When full, the pop frees the slot the push lands in (wr_ptr == rd_ptr);
  // the head is read combinationally before the edge overwrites it.
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock_in) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dac_sample_scheduler
//  Purpose  : Elastic stage between the ADC SPI receiver and the DAC SPI
//             serializer. Buffers received samples and releases exactly one
//             {command, sample} word per sample period; primes before
//             playback and holds the last value on underrun.
//  Ports    : clock_in, reset   - clock, sync active-high reset
//             in_data, in_strobe- ADC sample and its (level) valid strobe
//             dac_busy          - serializer mid-frame, blocks issue
//             clear_flags       - clears sticky overrun/underrun
//             dac_data, send    - registered DAC word and 1-cycle strobe
//             fifo_level        - FIFO occupancy
//             overrun, underrun - sticky status flags
//             overrun_count, underrun_count - only with SCHED_STATS_EN
//  Config   : SCHED_STATS_EN adds saturating 16-bit event counters.
//  Revision : 1.0  initial release
// ============================================================================
module dac_sample_scheduler
  import sched_pkg::*;
#(
  parameter int         SAMPLE_INTERVAL = 2015,
  parameter int         ADDR_W          = 3,
  parameter int         PRIME_LEVEL     = 4,
  parameter logic [7:0] DAC_CMD         = DAC_CMD_CH_A
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic [SAMPLE_W-1:0]   in_data,
  input  logic                  in_strobe,
  input  logic                  dac_busy,
  input  logic                  clear_flags,
  output logic [DAC_WORD_W-1:0] dac_data,
  output logic                  send,
  output logic [ADDR_W:0]       fifo_level,
  output logic                  overrun,
  output logic                  underrun
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]           overrun_count,
  output logic [15:0]           underrun_count
`endif
);

  localparam logic [15:0]   TIMER_LAST = 16'(SAMPLE_INTERVAL - 1);
  localparam logic [ADDR_W:0] PRIME    = (ADDR_W+1)'(PRIME_LEVEL);

  state_t              state;
  logic                strobe_q;
  logic [15:0]         timer;
  logic                pending;

  logic                push_edge;
  logic                tick;
  logic                issue;
  logic                pop;
  logic                ovr_evt;
  logic                und_evt;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;

  // One push per strobe, however long the receiver holds it high.
  assign push_edge = in_strobe & ~strobe_q;
  assign tick      = (timer == TIMER_LAST);
  assign issue     = pending & ~dac_busy;
  assign pop       = issue & (state == RUN) & ~fifo_empty;
  assign ovr_evt   = push_edge & fifo_full & ~pop;
  // A push in the issue cycle is not yet visible, so it still underruns.
  assign und_evt   = issue & (state == RUN) & fifo_empty;

  sample_fifo #(
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_fifo (
    .clock_in (clock_in),
    .reset    (reset),
    .push     (push_edge),
    .pop      (pop),
    .wdata    (in_data),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= FILL;
      strobe_q <= 1'b0;
      timer    <= '0;
      pending  <= 1'b0;
      send     <= 1'b0;
      dac_data <= make_word(DAC_CMD, '0);
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      strobe_q <= in_strobe;
      timer    <= tick ? '0 : timer + 16'd1;
      // A tick while a send is still owed merges with it; a tick in the
      // issue cycle itself starts a fresh pending request.
      pending  <= tick | (pending & ~issue);
      send     <= issue;

      if (pop) begin
        dac_data <= make_word(DAC_CMD, fifo_rdata);
      end

      case (state)
        FILL:    if (fifo_level >= PRIME) state <= RUN;
        RUN:     if (und_evt)             state <= FILL;
        default: state <= FILL;
      endcase

      // New events take priority over a simultaneous clear.
      if (ovr_evt)          overrun <= 1'b1;
      else if (clear_flags) overrun <= 1'b0;
      if (und_evt)          underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clock_in) begin
    if (reset) begin
      overrun_count  <= '0;
      underrun_count <= '0;
    end else begin
      if (ovr_evt && overrun_count != 16'hFFFF)  overrun_count  <= overrun_count + 16'd1;
      if (und_evt && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_sample_scheduler
//  Purpose  : Directed self-checking bench for dac_sample_scheduler with a
//             32-clock sample interval: priming, level strobe, overrun,
//             underrun, busy deferral and mid-run reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_strobe;
  logic        dac_busy;
  logic        clear_flags;
  logic [23:0] dac_data;
  logic        send;
  logic [3:0]  fifo_level;
  logic        overrun;
  logic        underrun;
`ifdef SCHED_STATS_EN
  logic [15:0] overrun_count;
  logic [15:0] underrun_count;
`endif

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int prev_send = 0;
  int gap    = 0;

  dac_sample_scheduler #(
    .SAMPLE_INTERVAL (32),
    .ADDR_W          (3),
    .PRIME_LEVEL     (4)
  ) dut (
    .clock_in       (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_strobe      (in_strobe),
    .dac_busy       (dac_busy),
    .clear_flags    (clear_flags),
    .dac_data       (dac_data),
    .send           (send),
    .fifo_level     (fifo_level),
    .overrun        (overrun),
    .underrun       (underrun)
`ifdef SCHED_STATS_EN
    ,
    .overrun_count  (overrun_count),
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sample(input logic [15:0] d);
    in_data   = d;
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
    step();
  endtask

  // Advance until a send pulse is seen (bounded); records gap since last send.
  task automatic wait_send(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (send !== 1'b1 && n < 200);
    check({tag, "_send_seen"}, {31'd0, send}, 32'd1);
    gap       = cycle - prev_send;
    prev_send = cycle;
  endtask

  initial begin
    int busy_sends;
    reset = 1'b1; in_data = '0; in_strobe = 1'b0; dac_busy = 1'b0; clear_flags = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_dac_data", dac_data, 24'h310000);
    check("rst_send", send, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_underrun", underrun, 0);
    reset = 1'b0;

    // 1: prime
    push_sample(16'h1111);
    push_sample(16'h2222);
    push_sample(16'h3333);
    wait_send("fill");
    check("fill_value", dac_data, 24'h310000);
    check("fill_level", fifo_level, 3);
    push_sample(16'h4444);
    check("prime_level", fifo_level, 4);
    wait_send("run1");
    check("run1_value", dac_data, 24'h311111);
    check("run1_gap", gap, 32);
    wait_send("run2");
    check("run2_value", dac_data, 24'h312222);
    check("run2_gap", gap, 32);
    wait_send("run3");
    check("run3_value", dac_data, 24'h313333);
    wait_send("run4");
    check("run4_value", dac_data, 24'h314444);
    check("run4_gap", gap, 32);

    // 4: underrun
    check("pre_und_flag", underrun, 0);
    wait_send("und");
    check("und_value", dac_data, 24'h314444);
    check("und_gap", gap, 32);
    check("und_flag", underrun, 1);
    wait_send("und_hold");
    check("und_hold_value", dac_data, 24'h314444);
    check("und_sticky", underrun, 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("und_cleared", underrun, 0);

    // 2: level strobe
    in_data   = 16'hABCD;
    in_strobe = 1'b1;
    repeat (50) step();
    in_strobe = 1'b0;
    step();
    check("lvl_strobe_level", fifo_level, 1);
    check("fill_no_underrun", underrun, 0);

    // 3: overrun (fresh start, all pushes before the first tick)
    reset = 1'b1;
    step();
    reset = 1'b0;
    prev_send = cycle;
    for (int i = 1; i <= 9; i++) push_sample(16'(i));
    check("ovr_level", fifo_level, 8);
    check("ovr_flag", overrun, 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("ovr_cleared", overrun, 0);
    for (int i = 1; i <= 8; i++) begin
      wait_send("drain");
      check($sformatf("drain_value%0d", i), dac_data, {8'h31, 16'(i)});
    end
    wait_send("drain_und");
    check("no_9th_sample", dac_data, 24'h310008);
    check("drain_und_flag", underrun, 1);
    check("drain_level", fifo_level, 0);

    // 5: busy defer across two ticks
    wait_send("busy_sync");
    dac_busy   = 1'b1;
    busy_sends = 0;
    repeat (70) begin
      step();
      if (send === 1'b1) busy_sends++;
    end
    check("busy_no_send", busy_sends, 0);
    dac_busy = 1'b0;
    step();
    check("busy_release_send", send, 1);
    prev_send = cycle;
    step();
    check("busy_single_pulse", send, 0);
    wait_send("busy_next");
    check("busy_next_gap", gap, 25);

    // 6: reset mid-run with level 5
    wait_send("rst_sync");
    for (int i = 0; i < 5; i++) push_sample(16'h5000 + 16'(i));
    check("pre_rst_level", fifo_level, 5);
`ifdef SCHED_STATS_EN
    check("ovr_count", overrun_count, 1);
    check("und_count", underrun_count, 1);
`endif
    reset = 1'b1;
    step();
    check("midrst_level", fifo_level, 0);
    check("midrst_send", send, 0);
    check("midrst_dac_data", dac_data, 24'h310000);
    check("midrst_underrun", underrun, 0);
`ifdef SCHED_STATS_EN
    check("midrst_ovr_count", overrun_count, 0);
    check("midrst_und_count", underrun_count, 0);
`endif
    reset = 1'b0;
    push_sample(16'h7777);
    wait_send("post_rst");
    check("post_rst_fill_value", dac_data, 24'h310000);
    check("post_rst_level", fifo_level, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
